// File: rtl/count_seq_ctrl.sv
// Command sequencer for a 4-bit loadable up/down counter.
// Accepts CLEAR / LOAD / UP-n / DOWN-n over valid/ready and drives the
// counter pins. Between commands the counter is frozen by re-loading its
// own count. Completion is flagged by a one-cycle done pulse. The captured
// count appears on result from the cycle after done.
module count_seq_ctrl #(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [3:0]        ctr_count,
    output logic [3:0]        ctr_din,
    output logic              ctr_load,
    output logic              ctr_up_down,
    output logic              ctr_resetn,
    output logic              busy,
    output logic              done,
    output logic [3:0]        result,
    output logic              err
);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StClr,
        StLoad,
        StRun,
        StDone
    } state_t;

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;

    state_t            state_q;
    logic [3:0]        data_q;
    logic [STEP_W-1:0] remaining_q;
    logic              dir_q;
    logic [3:0]        result_q;
    logic              err_q;

    // Sequencer state and the registers latched per command.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StInit;
            data_q      <= 4'd0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            result_q    <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: state_q <= StIdle;
                StIdle: begin
                    if (cmd_valid) begin
                        data_q      <= cmd_data;
                        remaining_q <= cmd_steps;
                        dir_q       <= cmd_op[0];
                        err_q       <= 1'b0;
                        if (cmd_op == OpClear) begin
                            state_q <= StClr;
                        end else if (cmd_op == OpLoad) begin
                            state_q <= StLoad;
                        end else if (cmd_steps == '0) begin
                            // Zero-length run: report without touching the counter.
                            state_q <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StClr: state_q <= StDone;
                StLoad: begin
                    // Out-of-range values are still loaded, only flagged.
                    err_q   <= (data_q < 4'd2) || (data_q > 4'd10);
                    state_q <= StDone;
                end
                StRun: begin
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == STEP_W'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result_q <= ctr_count;
                    state_q  <= StIdle;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Counter pin and status decode from the registered state.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ctr_resetn  = 1'b1;
        ctr_load    = 1'b0;
        ctr_up_down = 1'b0;
        ctr_din     = 4'd0;
        unique case (state_q)
            StInit: begin
                ctr_resetn = 1'b0;
            end
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                ctr_load  = 1'b1;
                ctr_din   = ctr_count;
            end
            StClr: begin
                ctr_resetn = 1'b0;
            end
            StLoad: begin
                ctr_load = 1'b1;
                ctr_din  = data_q;
            end
            StRun: begin
                ctr_up_down = dir_q;
            end
            StDone: begin
                ctr_load = 1'b1;
                ctr_din  = ctr_count;
                done     = 1'b1;
            end
            default: begin
                ctr_resetn = 1'b0;
            end
        endcase
    end

    assign result = result_q;
    assign err    = err_q;

endmodule
